// File: rtl/niu_sii_req_sched.sv
// niu_sii_req_sched: round-robin NIU->SII DMA request scheduler with OQ/BQ credit tracking
// Ports: iol2clk/rst_l (sync, active-low); req_* per-requester request, header and payload;
// req_gnt (comb one-hot grant), req_pld_rd (registered beat strobe); sii_niu_oqdq/bqdq credit returns;
// niu_sii_* registered bus (header cycle, then four 16B beats for writes); credit_err sticky overflow flag.
module niu_sii_req_sched #(
  parameter int NREQ = 2,
  parameter int OQ_CREDITS = 16,
  parameter int BQ_CREDITS = 16
) (
  input  logic                  iol2clk,
  input  logic                  rst_l,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ-1:0]       req_bypass,
  input  logic [NREQ*128-1:0]   req_hdr,
  input  logic [NREQ*128-1:0]   req_pld,
  input  logic [NREQ*16-1:0]    req_pld_be,
  output logic [NREQ-1:0]       req_gnt,
  output logic [NREQ-1:0]       req_pld_rd,
  input  logic                  sii_niu_oqdq,
  input  logic                  sii_niu_bqdq,
  output logic                  niu_sii_hdr_vld,
  output logic                  niu_sii_reqbypass,
  output logic                  niu_sii_datareq,
  output logic                  niu_sii_datareq16,
  output logic [127:0]          niu_sii_data,
  output logic [7:0]            niu_sii_parity,
  output logic [15:0]           niu_sii_be,
  output logic                  credit_err
);
  localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int OW = $clog2(OQ_CREDITS + 1);
  localparam int BW = $clog2(BQ_CREDITS + 1);
  localparam logic [0:0] IDLE = 1'b0, WPLD = 1'b1;
  logic [0:0] st;
  logic [1:0] cnt;
  logic [RW-1:0] rr, w, sel;
  logic [OW-1:0] oq_cr;
  logic [BW-1:0] bq_cr;
  logic [NREQ-1:0] elig;
  logic found, gnt_vld, wr_s, byp_s, dec_oq, dec_bq, oq_full, bq_full;
  logic [127:0] nxt_data;
  logic [15:0] nxt_be;
  logic [7:0] nxt_par;
  always_comb begin
    elig = '0;
    found = 1'b0;
    sel = '0;
    for (int k = 0; k < NREQ; k++)
      elig[k] = req_vld[k] && (req_bypass[k] ? bq_cr != '0 : oq_cr != '0);
    // first eligible requester at or after rr, wrapping
    for (int k = 0; k < NREQ; k++)
      if (!found && elig[(int'(rr) + k) % NREQ]) begin
        found = 1'b1;
        sel = RW'((int'(rr) + k) % NREQ);
      end
  end
  assign gnt_vld = rst_l && st == IDLE && found;
  assign req_gnt = gnt_vld ? NREQ'(1) << sel : '0;
  assign wr_s = req_wr[sel];
  assign byp_s = req_bypass[sel];
  assign dec_oq = gnt_vld && !byp_s;
  assign dec_bq = gnt_vld && byp_s;
  assign oq_full = oq_cr == OW'(OQ_CREDITS);
  assign bq_full = bq_cr == BW'(BQ_CREDITS);
  assign niu_sii_datareq16 = 1'b0;
  always_comb begin
    nxt_data = gnt_vld ? req_hdr[sel*128 +: 128] : st == WPLD ? req_pld[w*128 +: 128] : '0;
    nxt_be = st == WPLD ? req_pld_be[w*16 +: 16] : '0;
    nxt_par = '0;
    for (int k = 0; k < 8; k++)
      nxt_par[k] = ^nxt_data[16*k +: 16];
  end
  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      st <= IDLE;
      cnt <= '0;
      rr <= '0;
      w <= '0;
      oq_cr <= OW'(OQ_CREDITS);
      bq_cr <= BW'(BQ_CREDITS);
      credit_err <= 1'b0;
      req_pld_rd <= '0;
      niu_sii_hdr_vld <= 1'b0;
      niu_sii_reqbypass <= 1'b0;
      niu_sii_datareq <= 1'b0;
      niu_sii_data <= '0;
      niu_sii_be <= '0;
      niu_sii_parity <= '0;
    end else begin
      if (gnt_vld) rr <= sel == RW'(NREQ - 1) ? '0 : sel + 1'b1;
      if (gnt_vld && wr_s) begin
        st <= WPLD;
        cnt <= '0;
        w <= sel;
      end else if (st == WPLD) begin
        cnt <= cnt + 1'b1;
        if (cnt == 2'd3) st <= IDLE;
      end
      // strobe leads the bus by one cycle: covers the header cycle plus beats 0..2 of WPLD
      req_pld_rd <= gnt_vld && wr_s ? NREQ'(1) << sel : st == WPLD && cnt != 2'd3 ? NREQ'(1) << w : '0;
      niu_sii_hdr_vld <= gnt_vld;
      niu_sii_datareq <= gnt_vld && wr_s;
      niu_sii_reqbypass <= gnt_vld && byp_s;
      niu_sii_data <= nxt_data;
      niu_sii_be <= nxt_be;
      niu_sii_parity <= nxt_par;
      oq_cr <= dec_oq && !sii_niu_oqdq ? oq_cr - 1'b1 : sii_niu_oqdq && !dec_oq && !oq_full ? oq_cr + 1'b1 : oq_cr;
      bq_cr <= dec_bq && !sii_niu_bqdq ? bq_cr - 1'b1 : sii_niu_bqdq && !dec_bq && !bq_full ? bq_cr + 1'b1 : bq_cr;
      credit_err <= credit_err | (sii_niu_oqdq && !dec_oq && oq_full) | (sii_niu_bqdq && !dec_bq && bq_full);
    end
  end
endmodule

// File: tb/tb_niu_sii_req_sched.sv
// tb_niu_sii_req_sched: directed plus randomized check of the request scheduler against a cycle model
module tb_niu_sii_req_sched;
  localparam int NREQ = 2;
  localparam int OQ = 2;
  localparam int BQ = 16;
  logic iol2clk, rst_l;
  logic [NREQ-1:0] req_vld, req_wr, req_bypass, req_gnt, req_pld_rd;
  logic [NREQ*128-1:0] req_hdr, req_pld;
  logic [NREQ*16-1:0] req_pld_be;
  logic sii_niu_oqdq, sii_niu_bqdq;
  logic niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16, credit_err;
  logic [127:0] niu_sii_data;
  logic [7:0] niu_sii_parity;
  logic [15:0] niu_sii_be;
  niu_sii_req_sched #(.NREQ(NREQ), .OQ_CREDITS(OQ), .BQ_CREDITS(BQ)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l), .req_vld(req_vld), .req_wr(req_wr), .req_bypass(req_bypass),
    .req_hdr(req_hdr), .req_pld(req_pld), .req_pld_be(req_pld_be), .req_gnt(req_gnt),
    .req_pld_rd(req_pld_rd), .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
    .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
    .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
    .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity), .niu_sii_be(niu_sii_be),
    .credit_err(credit_err)
  );
  typedef struct packed {
    logic hv, dr, rb;
    logic [127:0] d;
    logic [15:0] be;
    logic [7:0] p;
    logic [NREQ-1:0] prd;
  } bus_t;
  bus_t sched [8];
  int errs = 0, checks = 0, cyc = 0;
  int m_rr, m_oq, m_bq, busy, m_w;
  logic m_err;
  initial begin
    iol2clk = 1'b0;
    forever #5 iol2clk = ~iol2clk;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [7:0] par(input logic [127:0] d);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = ^d[16*k +: 16];
    return r;
  endfunction
  task automatic drv(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] b, input logic oq, input logic bq);
    req_vld = v;
    req_wr = wr;
    req_bypass = b;
    sii_niu_oqdq = oq;
    sii_niu_bqdq = bq;
  endtask
  // one clock: check registered outputs for this cycle, check grant, advance the model, move to next negedge
  task automatic step();
    bus_t s;
    int g, n;
    logic dec_o, dec_b;
    logic [NREQ-1:0] eg;
    #1;
    s = sched[cyc % 8];
    chk("hdr_vld", niu_sii_hdr_vld, s.hv);
    chk("datareq", niu_sii_datareq, s.dr);
    chk("reqbypass", niu_sii_reqbypass, s.rb);
    chk("datareq16", niu_sii_datareq16, 1'b0);
    chk("data", niu_sii_data, s.d);
    chk("be", niu_sii_be, s.be);
    chk("parity", niu_sii_parity, s.p);
    chk("pld_rd", req_pld_rd, s.prd);
    chk("credit_err", credit_err, m_err);
    sched[cyc % 8] = '0;
    n = (cyc + 1) % 8;
    g = -1;
    eg = '0;
    dec_o = 1'b0;
    dec_b = 1'b0;
    if (!rst_l) begin
      m_rr = 0; m_oq = OQ; m_bq = BQ; m_err = 1'b0; busy = 0;
      for (int i = 0; i < 8; i++) sched[i] = '0;
    end else begin
      if (busy == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_rr + k) % NREQ;
          if (g < 0 && req_vld[i] && (req_bypass[i] ? m_bq > 0 : m_oq > 0)) g = i;
        end
      end else begin
        sched[n].d = req_pld[m_w*128 +: 128];
        sched[n].be = req_pld_be[m_w*16 +: 16];
        sched[n].p = par(req_pld[m_w*128 +: 128]);
        if (busy > 1) sched[n].prd = NREQ'(1) << m_w;
        busy--;
      end
      if (g >= 0) begin
        eg = NREQ'(1) << g;
        sched[n].hv = 1'b1;
        sched[n].dr = req_wr[g];
        sched[n].rb = req_bypass[g];
        sched[n].d = req_hdr[g*128 +: 128];
        sched[n].p = par(req_hdr[g*128 +: 128]);
        if (req_wr[g]) begin
          sched[n].prd = NREQ'(1) << g;
          busy = 4;
          m_w = g;
        end
        m_rr = (g + 1) % NREQ;
        dec_o = !req_bypass[g];
        dec_b = req_bypass[g];
      end
      if (dec_o && !sii_niu_oqdq) m_oq--;
      else if (sii_niu_oqdq && !dec_o) begin
        if (m_oq == OQ) m_err = 1'b1; else m_oq++;
      end
      if (dec_b && !sii_niu_bqdq) m_bq--;
      else if (sii_niu_bqdq && !dec_b) begin
        if (m_bq == BQ) m_err = 1'b1; else m_bq++;
      end
    end
    chk("req_gnt", req_gnt, eg);
    cyc++;
    @(negedge iol2clk);
  endtask
  initial begin
    m_rr = 0; m_oq = OQ; m_bq = BQ; m_err = 1'b0; busy = 0; m_w = 0;
    for (int i = 0; i < 8; i++) sched[i] = '0;
    rst_l = 1'b0;
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    req_hdr = '0;
    req_pld = '0;
    req_pld_be = '0;
    @(negedge iol2clk);
    step();
    step();
    rst_l = 1'b1;
    // single ordered read from req0
    req_hdr[127:0] = {48'h0, 16'h0005, 24'h0, 40'h12_3456_7880};
    drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    step();
    // single bypass write from req1, beats 0xA..0xD
    req_hdr[255:128] = {48'h0, 16'h0042, 24'h0, 40'hAB_CDEF_0120};
    req_pld_be = {16'hFFFF, 16'h0};
    drv(2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
    step();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int b = 'hA; b <= 'hD; b++) begin
      req_pld[255:128] = 128'(b);
      step();
    end
    step();
    step();
    // round-robin bypass reads, back-to-back
    drv(2'b11, 2'b00, 2'b11, 1'b0, 1'b0);
    repeat (6) step();
    drv(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    // ordered credit exhaustion, refill, and dq coincident with grant
    drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (4) step();
    drv(2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    drv(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    drv(2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    step();
    // bypass refill to full, then one overflow dq
    drv(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    repeat (12) step();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (3) step();
    // reset during payload beat 2, then req1 granted right after reset
    drv(2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    step();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    req_pld[127:0] = 128'h1111;
    step();
    req_pld[127:0] = 128'h2222;
    step();
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    drv(2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (3) step();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_l = $urandom_range(0, 199) != 0;
      req_vld = NREQ'($urandom);
      req_wr = NREQ'($urandom);
      req_bypass = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_hdr[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_pld[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_pld_be[i*16 +: 16] = 16'($urandom);
      end
      sii_niu_oqdq = m_oq < OQ && $urandom_range(0, 2) == 0;
      sii_niu_bqdq = m_bq < BQ && $urandom_range(0, 3) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/niu_sii_req_sched.md
# niu_sii_req_sched

Request scheduler on the NIU side of the NIU→SII inbound DMA interface. It arbitrates round-robin among `NREQ` DMA requesters. It tracks SII ordered-queue and bypass-queue credits. It sequences each granted request onto the shared `niu_sii_*` bus: a header cycle, followed by four 16-byte payload cycles for writes.

## Interface

- `NREQ`, 2: number of DMA requesters (2..8).
- `OQ_CREDITS`, 16: SII ordered-queue entries.
- `BQ_CREDITS`, 16: SII bypass-queue entries.

Ports:

- `iol2clk` in 1: clock. One clock domain.
- `rst_l` in 1: reset, synchronous, active-low.
- `req_vld` in NREQ: requester i has a request pending.
- `req_wr` in NREQ: 1 = 64B DMA write, 0 = DMA read.
- `req_bypass` in NREQ: 1 = bypass queue, 0 = ordered queue.
- `req_hdr` in NREQ*128: header for requester i (tag [79:64], PA [39:0]).
- `req_pld` in NREQ*128: current write payload beat.
- `req_pld_be` in NREQ*16: byte enables of the current beat.
- `req_gnt` out NREQ: one-hot, one-cycle pulse when the header is accepted.
- `req_pld_rd` out NREQ: payload beat sampled this cycle. The requester advances to the next beat.
- `sii_niu_oqdq` in 1: one ordered-queue entry freed.
- `sii_niu_bqdq` in 1: one bypass-queue entry freed.
- `niu_sii_hdr_vld`, `niu_sii_reqbypass`, `niu_sii_datareq`, `niu_sii_datareq16` out 1 each: bus controls.
- `niu_sii_data` out 128: bus data.
- `niu_sii_parity` out 8: bus parity.
- `niu_sii_be` out 16: bus byte enables.
- `credit_err` out 1: sticky flag, set on a dequeue received while the credit counter is full.

## Operation

- FSM states:
  - `IDLE`: arbitration permitted every cycle.
  - `WPLD`: payload beat counter `cnt` 0..3. Arbitration is blocked.
- **Eligibility**: requester i is eligible when `req_vld[i]` is set and its target queue credit is > 0.
- **Arbitration**: in `IDLE`, pick the first eligible requester at or after the round-robin pointer `rr`, wrapping modulo NREQ.
- **Decision cycle T**:
  - pulse `req_gnt[w]`;
  - decrement the selected queue's credit;
  - set `rr` to (w+1) mod NREQ;
  - register the header.
  - If `req_wr[w]` is set, go to `WPLD` with cnt=0 and latch w.
- **`WPLD`**: assert `req_pld_rd[w]` every cycle, register `req_pld`/`req_pld_be`, and increment `cnt`. Return to `IDLE` after cnt=3.
- **Credits**: independent counters, width $clog2(N+1), reset to full.
  - A decrement and a dq in the same cycle leave the count unchanged.
  - A dq while the counter is full saturates the counter and sets `credit_err`.
- **Header bus cycle**:
  - `hdr_vld`=1;
  - `datareq`=req_wr;
  - `reqbypass`=req_bypass;
  - `data`=header;
  - `be`=0.
- **Payload bus cycle**: `hdr_vld`=`datareq`=`reqbypass`=0; `data`/`be` = beat.
- **Idle bus cycle**: all controls 0 and `data`/`be` 0.
- `niu_sii_datareq16` is always 0. This block issues only 64B writes.
- **Parity**: `niu_sii_parity[k]` = XOR of `niu_sii_data[16k+15:16k]`, valid on header and payload cycles and 0 otherwise.
- A requester with `req_vld`=1 and no credit is skipped. `rr` does not advance for it.
- After a grant, a requester that reasserts `req_vld` competes in the next decision.

## Timing

- All `niu_sii_*` outputs and `req_pld_rd` are registered. `req_gnt` is combinational from registered state and the inputs.
- **Read**: decision at T, header on bus at T+1. The next decision may also be at T+1, giving back-to-back headers with no gap.
- **Write**: decision at T, header at T+1.
  - `req_pld_rd` is high during T+1..T+4.
  - Payload beats 0..3 are on the bus at T+2..T+5.
  - The next decision comes at T+5 at the earliest, so the next header appears at T+6 with no bus bubble.
- **Reset**: `rst_l`=0 at any edge, including mid-payload, forces:
  - all outputs to 0;
  - FSM to `IDLE` and `rr`=0;
  - credits to `OQ_CREDITS`/`BQ_CREDITS`;
  - `credit_err` cleared.
  
  A partially sent write is abandoned. `req_gnt` is 0 while `rst_l`=0.
- dq inputs are honoured in every state, including `WPLD`.

## Test plan

- **Single read**: req0 read, ordered, hdr PA=0x12_3456_7880, tag 0x0005 -> `req_gnt`=01 at T; at T+1 `hdr_vld`=1, `datareq`=0, `reqbypass`=0, `data[39:0]`=0x1234567880; OQ credit 16→15.
- **Single write**: req1 write, bypass, beats 0xA..0xD -> header at T+1 with `datareq`=1, `reqbypass`=1; `data`=0xA,0xB,0xC,0xD at T+2..T+5; `req_pld_rd`=10 for 4 cycles; parity matches per-16-bit XOR.
- **Round-robin**: both requesters issue continuous reads -> grants alternate 01,10,01,10 on consecutive cycles; headers back-to-back.
- **Credit exhaustion**: OQ_CREDITS=2, three ordered reads from req0 with no dq -> two grants, then stall. One `sii_niu_oqdq` pulse -> the third grant in the following cycle. A dq pulsed together with a grant leaves the count unchanged.
- **Overflow**: `sii_niu_bqdq` pulsed with the bypass credit at 16 -> count stays 16 and `credit_err`=1 until reset.
- **Reset mid-write**: `rst_l`=0 during payload beat 2 -> next cycle all bus outputs 0, credits full, `rr`=0. The first post-reset request from req1 is granted at the first cycle after reset deasserts.
